// File: rtl/scaled_bg_pkg.sv
// scaled_bg_pkg: shared screen defaults, colour type and width helper for the background renderer
package scaled_bg_pkg;
   localparam int SCREEN_W_DEF = 640;
   localparam int SCREEN_H_DEF = 480;
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb4_t;
   function automatic int w_of(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/raster_dda_step.sv
// raster_dda_step: one-axis divider-free scaler tracking a wrapping texel counter and its address base
module raster_dda_step
   import scaled_bg_pkg::*;
#(
   parameter int SRC_N = 480,
   parameter int DST_N = 640,
   parameter int STEP = 1,
   parameter int BW = 18,
   localparam int CW = w_of(SRC_N),
   localparam int EW = w_of(SRC_N + DST_N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  logic [CW-1:0] load_cnt,
   input  logic [BW-1:0] load_base,
   output logic [BW-1:0] base
);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] base_q, base_d;
   logic [EW-1:0] err_q, err_d, sum;
   logic          inc, wrap;
   always_comb begin
      sum    = err_q + EW'(SRC_N);
      inc    = step && !load && sum >= EW'(DST_N);
      wrap   = cnt_q == CW'(SRC_N - 1);
      err_d  = load ? '0 : !step ? err_q : inc ? sum - EW'(DST_N) : sum;
      cnt_d  = load ? load_cnt : !inc ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
      base_d = load ? load_base : !inc ? base_q : wrap ? '0 : base_q + BW'(STEP);
   end
   assign base = base_d;
   always_ff @(posedge clk)
      if (rst) begin
         cnt_q  <= '0;
         base_q <= '0;
         err_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         base_q <= base_d;
         err_q  <= err_d;
      end
endmodule

// File: rtl/scaled_bg_renderer.sv
// scaled_bg_renderer: full-screen scaled indexed background with frame-synchronous scroll and transparent key
module scaled_bg_renderer
   import scaled_bg_pkg::*;
#(
   parameter int IMG_W = 480,
   parameter int IMG_H = 320,
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF,
   parameter int IDX_W = 4,
   parameter int TRANSP_EN = 1,
   parameter int TRANSP_IDX = 0,
   localparam int ADDR_W = w_of(IMG_W * IMG_H),
   localparam int XW = w_of(IMG_W),
   localparam int YW = w_of(IMG_H)
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic [XW-1:0]     scroll_x,
   input  logic [YW-1:0]     scroll_y,
   input  logic              scroll_valid,
   output logic              scroll_ack,
   output logic              scroll_err,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [IDX_W-1:0]  pal_index,
   input  logic [3:0]        pal_r,
   input  logic [3:0]        pal_g,
   input  logic [3:0]        pal_b,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              opaque
);
   logic              frame_start, scroll_ok, take, use_pend, y_step;
   logic              pend_q, pend_d, ack_q, ack_d, err_q, err_d, opaque_q, opaque_d;
   logic [XW-1:0]     pend_x_q, pend_x_d, app_x_q, app_x_d;
   logic [YW-1:0]     pend_y_q, pend_y_d, app_y_q, app_y_d;
   logic [ADDR_W-1:0] pend_base_q, pend_base_d, app_base_q, app_base_d;
   logic [ADDR_W-1:0] addr_q, addr_d, col, row_base;
   logic [9:0]        last_y_q, last_y_d;
   logic [1:0]        bl_q, bl_d;
   rgb4_t             rgb_q, rgb_d;
   always_comb begin
      frame_start = DrawX == '0 && DrawY == '0;
      scroll_ok   = {1'b0, scroll_x} < (XW+1)'(IMG_W) && {1'b0, scroll_y} < (YW+1)'(IMG_H);
      take        = scroll_valid && scroll_ok;
      use_pend    = frame_start && pend_q;
      pend_d      = take || (pend_q && !use_pend);
      pend_x_d    = take ? scroll_x : pend_x_q;
      pend_y_d    = take ? scroll_y : pend_y_q;
      pend_base_d = take ? ADDR_W'(scroll_y * IMG_W) : pend_base_q;
      app_x_d     = use_pend ? pend_x_q : app_x_q;
      app_y_d     = use_pend ? pend_y_q : app_y_q;
      app_base_d  = use_pend ? pend_base_q : app_base_q;
      ack_d       = use_pend;
      err_d       = scroll_valid && !scroll_ok;
      y_step      = DrawX == '0 && DrawY != last_y_q;
      last_y_d    = DrawX == '0 ? DrawY : last_y_q;
      addr_d      = row_base + col;
      bl_d        = {bl_q[0], blank};
      opaque_d    = bl_q[1] && !(TRANSP_EN != 0 && rom_q == IDX_W'(TRANSP_IDX));
      rgb_d       = opaque_d ? {pal_r, pal_g, pal_b} : '0;
   end
   raster_dda_step #(.SRC_N(IMG_W), .DST_N(SCREEN_W), .STEP(1), .BW(ADDR_W)) u_x (
      .clk(vga_clk), .rst(reset), .load(DrawX == '0), .step(1'b1),
      .load_cnt(app_x_d), .load_base(ADDR_W'(app_x_d)), .base(col)
   );
   raster_dda_step #(.SRC_N(IMG_H), .DST_N(SCREEN_H), .STEP(IMG_W), .BW(ADDR_W)) u_y (
      .clk(vga_clk), .rst(reset), .load(frame_start), .step(y_step),
      .load_cnt(app_y_d), .load_base(app_base_d), .base(row_base)
   );
   always_ff @(posedge vga_clk)
      if (reset) begin
         pend_q      <= '0;
         pend_x_q    <= '0;
         pend_y_q    <= '0;
         pend_base_q <= '0;
         app_x_q     <= '0;
         app_y_q     <= '0;
         app_base_q  <= '0;
         ack_q       <= '0;
         err_q       <= '0;
         last_y_q    <= '0;
         addr_q      <= '0;
         bl_q        <= '0;
         rgb_q       <= '0;
         opaque_q    <= '0;
      end else begin
         pend_q      <= pend_d;
         pend_x_q    <= pend_x_d;
         pend_y_q    <= pend_y_d;
         pend_base_q <= pend_base_d;
         app_x_q     <= app_x_d;
         app_y_q     <= app_y_d;
         app_base_q  <= app_base_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         last_y_q    <= last_y_d;
         addr_q      <= addr_d;
         bl_q        <= bl_d;
         rgb_q       <= rgb_d;
         opaque_q    <= opaque_d;
      end
   assign scroll_ack  = ack_q;
   assign scroll_err  = err_q;
   assign rom_address = addr_q;
   assign pal_index   = rom_q;
   assign red         = rgb_q.r;
   assign green       = rgb_q.g;
   assign blue        = rgb_q.b;
   assign opaque      = opaque_q;
endmodule
